// File: rtl/flex_updown_counter.sv
// Parameterised up/down counter with a runtime terminal value, wrap or saturate behaviour,
// and registered rollover, zero and wrap flags that change on the same edge as the count.
module flex_updown_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    dir,
    input  logic                    mode,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    zero_flag,
    output logic                    wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
    localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_rollover;
    logic                    r_zero;
    logic                    r_wrap;

    logic [NUM_CNT_BITS-1:0] w_next_count;
    logic                    w_wrap_evt;
    logic                    w_rv_valid;

    assign w_rv_valid = (rollover_val != CntZero);

    // The terminal comparisons run before any increment, so the all-ones count never overflows.
    always_comb begin
        w_next_count = r_count;
        w_wrap_evt   = 1'b0;
        if (clear) begin
            w_next_count = CntZero;
        end else if (load) begin
            w_next_count = load_val;
        end else if (count_enable && w_rv_valid) begin
            if (!dir) begin
                if (r_count >= rollover_val) begin
                    if (!mode) begin
                        w_next_count = CntOne;
                        w_wrap_evt   = 1'b1;
                    end
                end else begin
                    w_next_count = r_count + CntOne;
                end
            end else if (!mode) begin
                if (r_count <= CntOne) begin
                    w_next_count = rollover_val;
                    w_wrap_evt   = 1'b1;
                end else if (r_count > rollover_val) begin
                    w_next_count = rollover_val;
                end else begin
                    w_next_count = r_count - CntOne;
                end
            end else begin
                if (r_count > rollover_val) begin
                    w_next_count = rollover_val;
                end else if (r_count != CntZero) begin
                    w_next_count = r_count - CntOne;
                end
            end
        end
    end

    // Flags are derived from the next-state count so they line up with count_out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count    <= CntZero;
            r_rollover <= 1'b0;
            r_zero     <= 1'b1;
            r_wrap     <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_rollover <= w_rv_valid && (w_next_count == rollover_val);
            r_zero     <= (w_next_count == CntZero);
            r_wrap     <= w_wrap_evt;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_rollover;
    assign zero_flag     = r_zero;
    assign wrap_pulse    = r_wrap;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed and random stimulus for flex_updown_counter; expectations go through a scoreboard queue.
module tb_flex_updown_counter;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         clear = 1'b0;
    logic         count_enable = 1'b0;
    logic         dir = 1'b0;
    logic         mode = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic [N-1:0] rollover_val = '0;
    logic [N-1:0] count_out;
    logic         rollover_flag;
    logic         zero_flag;
    logic         wrap_pulse;

    typedef struct {
        string        tag;
        logic [N-1:0] cnt;
        logic         rf;
        logic         zf;
        logic         wp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_count  = 0;

    flex_updown_counter #(
        .NUM_CNT_BITS(N)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .clear        (clear),
        .count_enable (count_enable),
        .dir          (dir),
        .mode         (mode),
        .load         (load),
        .load_val     (load_val),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .zero_flag    (zero_flag),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference for one clock edge.
    function automatic void ref_next(input int c, input bit rst, input bit clr, input bit ld,
                                     input int lv, input bit en, input bit d, input bit m,
                                     input int rv, output int n, output bit w);
        n = c;
        w = 1'b0;
        if (rst) n = 0;
        else if (clr) n = 0;
        else if (ld) n = lv;
        else if (en && rv != 0) begin
            if (!d) begin
                if (c < rv) n = c + 1;
                else if (!m) begin
                    n = 1;
                    w = 1'b1;
                end
            end else if (!m) begin
                if (c <= 1) begin
                    n = rv;
                    w = 1'b1;
                end else if (c > rv) n = rv;
                else n = c - 1;
            end else begin
                if (c > rv) n = rv;
                else if (c > 0) n = c - 1;
            end
        end
    endfunction

    task automatic step(input string tag, input bit rst, input bit clr, input bit ld,
                        input int lv, input bit en, input bit d, input bit m, input int rv,
                        input int e_cnt, input bit e_wp);
        exp_t e;
        exp_t g;
        RST          = rst;
        clear        = clr;
        load         = ld;
        load_val     = N'(lv);
        count_enable = en;
        dir          = d;
        mode         = m;
        rollover_val = N'(rv);
        e.tag = tag;
        e.cnt = N'(e_cnt);
        e.rf  = (e_cnt == rv) && (rv != 0);
        e.zf  = (e_cnt == 0);
        e.wp  = e_wp;
        q.push_back(e);
        m_count = e_cnt;
        @(posedge CLK);
        #1;
        g = q.pop_front();
        n_checks++;
        assert (count_out === g.cnt) else begin
            n_errors++;
            $error("FAIL %s count_out got %0d want %0d", g.tag, count_out, g.cnt);
        end
        n_checks++;
        assert (rollover_flag === g.rf) else begin
            n_errors++;
            $error("FAIL %s rollover_flag got %b want %b", g.tag, rollover_flag, g.rf);
        end
        n_checks++;
        assert (zero_flag === g.zf) else begin
            n_errors++;
            $error("FAIL %s zero_flag got %b want %b", g.tag, zero_flag, g.zf);
        end
        n_checks++;
        assert (wrap_pulse === g.wp) else begin
            n_errors++;
            $error("FAIL %s wrap_pulse got %b want %b", g.tag, wrap_pulse, g.wp);
        end
    endtask

    initial begin
        int n;
        bit w;
        bit r_rst, r_clr, r_ld, r_en, r_d, r_m;
        int r_lv, r_rv;

        // tag, rst, clr, ld, lv, en, dir, mode, rv, exp count, exp wrap
        step("rst_init",  1, 0, 0, 0, 0, 0, 0, 3, 0, 0);

        step("upw_1",     0, 0, 0, 0, 1, 0, 0, 3, 1, 0);
        step("upw_2",     0, 0, 0, 0, 1, 0, 0, 3, 2, 0);
        step("upw_3",     0, 0, 0, 0, 1, 0, 0, 3, 3, 0);
        step("upw_wrap1", 0, 0, 0, 0, 1, 0, 0, 3, 1, 1);
        step("upw_2b",    0, 0, 0, 0, 1, 0, 0, 3, 2, 0);
        step("upw_3b",    0, 0, 0, 0, 1, 0, 0, 3, 3, 0);
        step("upw_wrap2", 0, 0, 0, 0, 1, 0, 0, 3, 1, 1);

        step("mid_load5", 0, 0, 1, 5, 0, 0, 0, 10, 5, 0);
        step("mid_up6",   0, 0, 0, 0, 1, 0, 0, 10, 6, 0);
        step("rst_mid1",  1, 0, 1, 9, 1, 0, 0, 10, 0, 0);
        step("rst_mid2",  1, 0, 1, 9, 1, 0, 0, 10, 0, 0);

        step("dnw_load2", 0, 0, 1, 2, 0, 1, 0, 5, 2, 0);
        step("dnw_1",     0, 0, 0, 0, 1, 1, 0, 5, 1, 0);
        step("dnw_wrap5", 0, 0, 0, 0, 1, 1, 0, 5, 5, 1);
        step("dnw_4",     0, 0, 0, 0, 1, 1, 0, 5, 4, 0);
        step("dnw_3",     0, 0, 0, 0, 1, 1, 0, 5, 3, 0);

        step("ups_load14", 0, 0, 1, 14, 0, 0, 1, 15, 14, 0);
        step("ups_15a",    0, 0, 0, 0, 1, 0, 1, 15, 15, 0);
        step("ups_15b",    0, 0, 0, 0, 1, 0, 1, 15, 15, 0);
        step("ups_15c",    0, 0, 0, 0, 1, 0, 1, 15, 15, 0);

        step("pri_clr_all",  0, 1, 1, 7, 1, 0, 0, 10, 0, 0);
        step("pri_load_en",  0, 0, 1, 9, 1, 0, 0, 10, 9, 0);
        step("tog_en1",      0, 0, 0, 0, 1, 0, 0, 10, 10, 0);
        step("tog_en0",      0, 0, 0, 0, 0, 0, 0, 10, 10, 0);
        step("tog_en1_wrap", 0, 0, 0, 0, 1, 0, 0, 10, 1, 1);
        step("tog_en0b",     0, 0, 0, 0, 0, 0, 0, 10, 1, 0);

        step("oor_load7",  0, 0, 1, 7, 0, 0, 0, 10, 7, 0);
        step("oor_up_rv4", 0, 0, 0, 0, 1, 0, 0, 4, 1, 1);
        step("rv0_load7",  0, 0, 1, 7, 0, 0, 0, 10, 7, 0);
        step("rv0_up",     0, 0, 0, 0, 1, 0, 0, 0, 7, 0);
        step("rv0_dn",     0, 0, 0, 0, 1, 1, 1, 0, 7, 0);

        step("dns_load0",  0, 0, 1, 0, 0, 1, 1, 5, 0, 0);
        step("dns_hold0",  0, 0, 0, 0, 1, 1, 1, 5, 0, 0);
        step("dns_load9",  0, 0, 1, 9, 0, 1, 1, 5, 9, 0);
        step("dns_clamp",  0, 0, 0, 0, 1, 1, 1, 5, 5, 0);
        step("dns_4",      0, 0, 0, 0, 1, 1, 1, 5, 4, 0);
        step("dnw_load9",  0, 0, 1, 9, 0, 1, 0, 5, 9, 0);
        step("dnw_clamp",  0, 0, 0, 0, 1, 1, 0, 5, 5, 0);
        step("dnw_load0",  0, 0, 1, 0, 0, 1, 0, 5, 0, 0);
        step("dnw_wrap0",  0, 0, 0, 0, 1, 1, 0, 5, 5, 1);

        step("ovf_load15", 0, 0, 1, 15, 0, 0, 0, 15, 15, 0);
        step("ovf_wrap",   0, 0, 0, 0, 1, 0, 0, 15, 1, 1);
        step("ovf_load15b",0, 0, 1, 15, 0, 0, 1, 15, 15, 0);
        step("ovf_sat",    0, 0, 0, 0, 1, 0, 1, 15, 15, 0);

        for (int i = 0; i < 300; i++) begin
            r_rst = ($urandom_range(0, 31) == 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_d   = $urandom_range(0, 1) != 0;
            r_m   = $urandom_range(0, 1) != 0;
            r_lv  = int'($urandom_range(0, 15));
            r_rv  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            ref_next(m_count, r_rst, r_clr, r_ld, r_lv, r_en, r_d, r_m, r_rv, n, w);
            step("rand", r_rst, r_clr, r_ld, r_lv, r_en, r_d, r_m, r_rv, n, w);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
